// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU, with retired-instruction counter.
// Optional memory watchdog: define SEQ_MEM_TIMEOUT_EN to compile it in.
module cpu_sequencer #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             carry,
   input  logic             mem_ready,
   output logic [2:0]       alu_op,
   output logic             regfile_we,
   output logic             pc_en,
   output logic             pc_load,
   output logic             ir_load,
   output logic             mem_we,
   output logic             mem_re,
   output logic [1:0]       sel_mux_a,
   output logic [1:0]       sel_mux_b,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_error,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_LDI   = 4'b0001;
   localparam logic [3:0] OP_MOV   = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_JMP   = 4'b0101;
   localparam logic [3:0] OP_JZ    = 4'b0110;
   localparam logic [3:0] OP_JC    = 4'b0111;
   localparam logic [3:0] OP_LOAD  = 4'b1000;
   localparam logic [3:0] OP_STORE = 4'b1001;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   state_t state, next_state;
   logic   retire;
   logic   timeout;

`ifdef SEQ_MEM_TIMEOUT_EN
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_cnt;
   logic              bus_err_q;
   logic              waiting;

   assign waiting = (state == FETCH) || (state == MEM);
   assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

   // Counts consecutive unanswered request cycles; any state change or ready restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if ((state != next_state) || mem_ready || !waiting)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + 1'b1;
         if (timeout)
            bus_err_q <= 1'b1;
      end
   end

   assign bus_error = bus_err_q;
`else
   assign timeout   = 1'b0;
   assign bus_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         instr_cnt <= '0;
      end else begin
         state <= next_state;
         if (retire)
            instr_cnt <= instr_cnt + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      retire     = 1'b0;
      alu_op     = 3'b000;
      regfile_we = 1'b0;
      pc_en      = 1'b0;
      pc_load    = 1'b0;
      ir_load    = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      sel_mux_a  = 2'b00;
      sel_mux_b  = 2'b00;
      halted     = 1'b0;
      illegal_op = 1'b0;

      case (state)
         IDLE: begin
            if (run)
               next_state = FETCH;
         end
         FETCH: begin
            mem_re = 1'b1;
            if (mem_ready) begin
               ir_load    = 1'b1;
               pc_en      = 1'b1;
               next_state = DECODE;
            end else if (timeout) begin
               next_state = HALT;
            end
         end
         DECODE: begin
            next_state = (opcode == OP_HALT) ? HALT : EXEC;
         end
         EXEC: begin
            retire = 1'b1;
            case (opcode)
               OP_LDI: begin
                  regfile_we = 1'b1;
                  sel_mux_a  = 2'b01;
               end
               OP_MOV, OP_ADD, OP_SUB: begin
                  regfile_we = 1'b1;
                  alu_op     = (opcode == OP_ADD) ? 3'b001 :
                               (opcode == OP_SUB) ? 3'b010 : 3'b000;
               end
               OP_JMP:  pc_load = 1'b1;
               OP_JZ:   pc_load = zero;
               OP_JC:   pc_load = carry;
               OP_LOAD, OP_STORE: begin
                  retire     = 1'b0;
                  next_state = MEM;
               end
               OP_NOP, OP_HALT: ;
               default: illegal_op = 1'b1;
            endcase
         end
         MEM: begin
            if (opcode == OP_LOAD) begin
               mem_re = 1'b1;
               if (mem_ready) begin
                  regfile_we = 1'b1;
                  sel_mux_a  = 2'b10;
               end
            end else begin
               mem_we = 1'b1;
            end
            if (mem_ready)
               retire = 1'b1;
            else if (timeout)
               next_state = HALT;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: next_state = IDLE;
      endcase

      // run is only consulted at the instruction boundary
      if (retire)
         next_state = run ? FETCH : IDLE;
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: driver queues per-cycle expected outputs, a negedge monitor compares.
// Watchdog vectors are included when SEQ_MEM_TIMEOUT_EN is defined.
module tb_cpu_sequencer;

   localparam int TB_CNT_W = 4;

   // expected output vectors: {alu_op, we, pc_en, pc_load, ir_load, mem_we, mem_re, sel_a, sel_b, halted, illegal, bus_error}
   localparam logic [15:0] E_ZERO      = 16'h0000;
   localparam logic [15:0] E_FETCH_W   = 16'h0080;
   localparam logic [15:0] E_FETCH_R   = 16'h0A80;
   localparam logic [15:0] E_ADD       = 16'h3000;
   localparam logic [15:0] E_SUB       = 16'h5000;
   localparam logic [15:0] E_LDI       = 16'h1020;
   localparam logic [15:0] E_MOV       = 16'h1000;
   localparam logic [15:0] E_JUMP      = 16'h0400;
   localparam logic [15:0] E_ILLEGAL   = 16'h0002;
   localparam logic [15:0] E_LOAD_W    = 16'h0080;
   localparam logic [15:0] E_LOAD_R    = 16'h10C0;
   localparam logic [15:0] E_STORE     = 16'h0100;
   localparam logic [15:0] E_HALTED    = 16'h0004;
   localparam logic [15:0] E_BUS_HALT  = 16'h0005;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                run;
   logic [3:0]          opcode;
   logic                zero;
   logic                carry;
   logic                mem_ready;
   logic [2:0]          alu_op;
   logic                regfile_we;
   logic                pc_en;
   logic                pc_load;
   logic                ir_load;
   logic                mem_we;
   logic                mem_re;
   logic [1:0]          sel_mux_a;
   logic [1:0]          sel_mux_b;
   logic                halted;
   logic                illegal_op;
   logic                bus_error;
   logic [TB_CNT_W-1:0] instr_cnt;

   typedef struct {
      logic [15:0] sig;
      logic [15:0] cnt;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] model_cnt = 16'h0;
   logic [15:0] act_sig;

   cpu_sequencer #(.CNT_W(TB_CNT_W), .MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .carry(carry),
      .mem_ready(mem_ready), .alu_op(alu_op), .regfile_we(regfile_we), .pc_en(pc_en),
      .pc_load(pc_load), .ir_load(ir_load), .mem_we(mem_we), .mem_re(mem_re),
      .sel_mux_a(sel_mux_a), .sel_mux_b(sel_mux_b), .halted(halted), .illegal_op(illegal_op),
      .bus_error(bus_error), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   assign act_sig = {alu_op, regfile_we, pc_en, pc_load, ir_load, mem_we, mem_re,
                     sel_mux_a, sel_mux_b, halted, illegal_op, bus_error};

   // Monitor: every queued cycle is compared mid-cycle, away from the rising edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_output(e);
      end
   end

   task automatic check_output(input exp_t e);
      logic [15:0] act_cnt;
      act_cnt = 16'(instr_cnt);
      checks++;
      if (act_sig !== e.sig || act_cnt !== e.cnt) begin
         errors++;
         $display("[TB] FAIL %s: got outputs=%h instr_cnt=%0d, expected outputs=%h instr_cnt=%0d",
                  e.name, act_sig, act_cnt, e.sig, e.cnt);
      end
   endtask

   // Drives one cycle of inputs and queues the outputs the sequencer must show during that cycle.
   task automatic apply_stimulus(input logic r, input logic rn, input logic [3:0] op,
                                 input logic z, input logic c, input logic rdy,
                                 input logic [15:0] exp_sig, input string nm);
      exp_t e;
      rst_n     = r;
      run       = rn;
      opcode    = op;
      zero      = z;
      carry     = c;
      mem_ready = rdy;
      if (!r)
         model_cnt = 16'h0;
      e.sig  = exp_sig;
      e.cnt  = model_cnt;
      e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Zero-wait single-cycle-execute instruction: FETCH, DECODE, EXEC, then retire.
   task automatic run_instr(input logic [3:0] op, input logic z, input logic c,
                            input logic [15:0] exec_sig, input logic rn, input string nm);
      apply_stimulus(1'b1, rn, op, z, c, 1'b1, E_FETCH_R, {nm, "_fetch"});
      apply_stimulus(1'b1, rn, op, z, c, 1'b1, E_ZERO,    {nm, "_decode"});
      apply_stimulus(1'b1, rn, op, z, c, 1'b1, exec_sig,  {nm, "_exec"});
      model_cnt = (model_cnt + 16'h1) & 16'h000F;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b1; opcode = 4'h0; zero = 1'b0; carry = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;

      apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, E_ZERO, "reset_hold0");
      apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, E_ZERO, "reset_hold1");
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO, "idle_after_reset");
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_FETCH_W, "fetch_wait");
      apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO, "reset_mid_fetch");
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, E_ZERO, "idle_restart");

      run_instr(4'h3, 1'b0, 1'b0, E_ADD,     1'b1, "add");
      run_instr(4'h4, 1'b0, 1'b0, E_SUB,     1'b1, "sub");
      run_instr(4'h1, 1'b0, 1'b0, E_LDI,     1'b1, "ldi");
      run_instr(4'h2, 1'b0, 1'b0, E_MOV,     1'b1, "mov");
      run_instr(4'h6, 1'b0, 1'b1, E_ZERO,    1'b1, "jz_not_taken");
      run_instr(4'h6, 1'b1, 1'b0, E_JUMP,    1'b1, "jz_taken");
      run_instr(4'h7, 1'b1, 1'b0, E_ZERO,    1'b1, "jc_not_taken");
      run_instr(4'h7, 1'b0, 1'b1, E_JUMP,    1'b1, "jc_taken");
      run_instr(4'h5, 1'b0, 1'b0, E_JUMP,    1'b1, "jmp");
      run_instr(4'h0, 1'b1, 1'b1, E_ZERO,    1'b1, "nop");

      apply_stimulus(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, E_FETCH_R, "load_fetch");
      apply_stimulus(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, E_ZERO,    "load_decode");
      apply_stimulus(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, E_ZERO,    "load_exec");
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, E_LOAD_W, "load_mem_wait");
      apply_stimulus(1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1, E_LOAD_R, "load_mem_ready");
      model_cnt = (model_cnt + 16'h1) & 16'h000F;

      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, E_FETCH_R, "store_fetch");
      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, E_ZERO,    "store_decode");
      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, E_ZERO,    "store_exec");
      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, E_STORE,   "store_mem_wait");
      apply_stimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, E_STORE,   "store_mem_ready");
      model_cnt = (model_cnt + 16'h1) & 16'h000F;

      run_instr(4'hA, 1'b0, 1'b0, E_ILLEGAL, 1'b1, "illegal_a");
      run_instr(4'hE, 1'b0, 1'b0, E_ILLEGAL, 1'b1, "illegal_e");

      // run dropped mid-instruction: ADD still completes, then the sequencer idles
      run_instr(4'h3, 1'b0, 1'b0, E_ADD,     1'b0, "add_run_low");
      apply_stimulus(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, E_ZERO, "idle_run_low");
      apply_stimulus(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, E_ZERO, "idle_run_high");

      // counter sits at 15 here; this NOP wraps it to 0
      run_instr(4'h0, 1'b0, 1'b0, E_ZERO,    1'b1, "nop_wrap");

      apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, E_FETCH_R, "halt_fetch");
      apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, E_ZERO,    "halt_decode");
      apply_stimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, E_HALTED,  "halt_run_low");
      apply_stimulus(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, E_HALTED,  "halt_run_high");
      apply_stimulus(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, E_HALTED,  "halt_run_toggle");
      apply_stimulus(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, E_ZERO,    "halt_reset");

`ifdef SEQ_MEM_TIMEOUT_EN
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO, "wd_idle");
      for (int i = 0; i < 4; i++)
         apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_FETCH_W, "wd_fetch_wait");
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_BUS_HALT, "wd_bus_error");
      apply_stimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, E_BUS_HALT, "wd_sticky");
      apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, E_ZERO,     "wd_reset_clears");
`endif

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It sits between the instruction register and the datapath (register file, ALU, PC, operand muxes, data memory). It replaces single-cycle opcode decoding with a state machine that waits on a memory ready handshake. It also counts retired instructions and reports halt and illegal-opcode conditions.

## Interface
Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- MEM_TIMEOUT, 15: maximum wait cycles for `mem_ready`. Used only when the watchdog is compiled in.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 permits fetching new instructions.
- opcode  input  4  IR[7:4]; stable from the cycle after `ir_load`.
- zero  input  1  registered ALU zero flag.
- carry  input  1  registered ALU carry flag.
- mem_ready  input  1  memory completes the current read or write this cycle.
- alu_op  output  3  000 pass, 001 ADD, 010 SUB.
- regfile_we  output  1  register file write enable.
- pc_en  output  1  PC increment.
- pc_load  output  1  PC load from immediate.
- ir_load  output  1  IR capture of memory data.
- mem_we  output  1  data memory write request.
- mem_re  output  1  memory read request (instruction or data).
- sel_mux_a  output  2  write-data source: 00 regfile, 01 immediate, 10 memory data.
- sel_mux_b  output  2  ALU operand B: 00 regfile, 01 immediate, 10 constant zero.
- halted  output  1  high while in HALT.
- illegal_op  output  1  one-cycle pulse in EXEC for opcodes 1010–1110.
- bus_error  output  1  sticky watchdog flag. Tied to 0 when the watchdog is compiled out.
- instr_cnt  output  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
State machine states: IDLE, FETCH, DECODE, EXEC, MEM, HALT. Outputs are combinational from state, opcode, flags and `mem_ready`. Any output not listed for a state is 0.

- IDLE: all outputs 0. If `run`=1, go to FETCH.
- FETCH: `mem_re`=1.
  - `mem_ready`=0: stay in FETCH.
  - `mem_ready`=1: `ir_load`=1 and `pc_en`=1 in that same cycle, then go to DECODE.
- DECODE: one cycle, all outputs 0. Opcode 1111 goes to HALT; every other opcode goes to EXEC.
- EXEC: one cycle. Outputs by opcode:
  - NOP 0000, and illegal opcodes 1010–1110: no outputs. Illegal opcodes also pulse `illegal_op`.
  - LDI 0001: `regfile_we`=1, `sel_mux_a`=01.
  - MOV 0010: `regfile_we`=1, `alu_op`=000, `sel_mux_b`=00, `sel_mux_a`=00.
  - ADD 0011: `regfile_we`=1, `alu_op`=001, `sel_mux_b`=00.
  - SUB 0100: `regfile_we`=1, `alu_op`=010, `sel_mux_b`=00.
  - JMP 0101: `pc_load`=1.
  - JZ 0110: `pc_load`=`zero`.
  - JC 0111: `pc_load`=`carry`.
  - LOAD 1000 and STORE 1001: no outputs in EXEC; go to MEM.
  - All other opcodes retire.
- MEM:
  - LOAD: `mem_re`=1. On `mem_ready`=1, also `regfile_we`=1 and `sel_mux_a`=10, then retire.
  - STORE: `mem_we`=1, held until `mem_ready`=1, then retire.
- Retire: `instr_cnt` increments on the transition out of the instruction. Next state is FETCH if `run`=1, else IDLE. `run` is sampled only at this boundary and in IDLE, so dropping `run` mid-instruction finishes the current instruction.
- HALT: `halted`=1, all other outputs 0. HALT is left only by reset. `run` is ignored. HALT does not increment `instr_cnt`.
- Reset asserted in any state immediately forces IDLE, all outputs 0, `instr_cnt`=0 and `bus_error`=0, including mid-handshake.

## Timing
- Reset values: every output 0; state IDLE.
- Zero-wait (`mem_ready` held 1) instruction latencies:
  - NOP/LDI/MOV/ADD/SUB/jumps: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD/STORE: 4 cycles.
- Each memory wait cycle adds 1 cycle. Requests stay asserted and stable until the `mem_ready` cycle.
- `zero`/`carry` are sampled in EXEC. They reflect the previous ALU instruction, because flags update at the end of that instruction's EXEC.
- `illegal_op` lasts exactly one cycle per illegal instruction.
- `instr_cnt` updates on the clock edge that leaves EXEC or MEM. At 2^CNT_W−1 it wraps to 0.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined: a wait counter runs in FETCH and MEM.
  - The counter clears on entry to either state and on `mem_ready`.
  - If it reaches MEM_TIMEOUT consecutive cycles without `mem_ready`, requests drop, `bus_error` sets (sticky until reset) and the state goes to HALT.
- SEQ_MEM_TIMEOUT_EN undefined: no counter exists, the sequencer waits indefinitely, and `bus_error` is constant 0.

## Test plan
- Reset and start: hold `rst_n`=0 with `run`=1, so all outputs are 0. Release `rst_n` → FETCH next cycle with `mem_re`=1. Assert `rst_n`=0 mid-FETCH → outputs 0 immediately.
- ADD zero-wait, opcode 0011, `mem_ready`=1:
  - cycle 1: `ir_load`=`pc_en`=1.
  - cycle 2: all outputs 0.
  - cycle 3: `regfile_we`=1, `alu_op`=001.
  - Then FETCH, with `instr_cnt` 0→1.
- Conditional jumps: JZ with `zero`=0 → `pc_load`=0 in EXEC; with `zero`=1 → `pc_load`=1. Repeat for JC with `carry`.
- LOAD with `mem_ready` delayed 3 cycles in MEM: `mem_re` high for 4 MEM cycles. `regfile_we`=1 with `sel_mux_a`=10 only in the ready cycle.
- Halt and illegal opcodes:
  - Opcode 1010 → one-cycle `illegal_op`, and `instr_cnt` increments.
  - Opcode 1111 → `halted`=1 after DECODE, and toggling `run` has no effect.
- Watchdog: SEQ_MEM_TIMEOUT_EN defined, MEM_TIMEOUT=4, `mem_ready` stuck at 0 in FETCH → after 4 cycles `mem_re`=0, `bus_error`=1, `halted`=1.
